// File: rtl/maze_link_rx.sv
// maze_link_rx: GPIO link receiver. Synchronises the Arduino strobe/data/address, assembles
// NCHUNKS-chunk records into a ROWS*COLS cell RAM. Optional idle timeout: MAZE_LINK_TIMEOUT_EN.
module maze_link_rx #(
  parameter int ROWS        = 4,
  parameter int COLS        = 5,
  parameter int CHUNK_W     = 3,
  parameter int NCHUNKS     = 3,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic [CHUNK_W-1:0]           LINK_DATA,
  input  logic                         LINK_STROBE,
  input  logic [ADDR_W-1:0]            LINK_ADDR,
  input  logic [ADDR_W-1:0]            RD_ADDR,
  output logic [CHUNK_W*NCHUNKS-1:0]   RD_DATA,
  output logic                         DONE,
  output logic                         BUSY,
  output logic                         REC_WE,
  output logic                         LINK_ERR
);
  localparam int REC_W = CHUNK_W * NCHUNKS;
  localparam int NCELL = ROWS * COLS;
  localparam int CNT_W = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam logic [ADDR_W-1:0] SYNC_ADDR = '1;
  localparam logic [ADDR_W-1:0] DONE_ADDR = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] NCELL_A   = ADDR_W'(NCELL);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NCELL - 1);
  localparam logic [CNT_W-1:0]  LAST_K    = CNT_W'(NCHUNKS - 1);

  if (NCELL > 2**ADDR_W - 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("maze_link_rx: unsupported parameter combination");
  end

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    clr_q, clr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REC_W-1:0]     part_q, part_d, ins;
  logic [ADDR_W-1:0]    lat_q, lat_d;
  logic                 done_q, done_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [REC_W-1:0]     rd_q;
  logic [2:0]           strb_q;
  logic [CHUNK_W-1:0]   data_s1_q, data_s2_q;
  logic [ADDR_W-1:0]    addr_s1_q, addr_s2_q;
  logic                 evt;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [REC_W-1:0]     mem_wdata;
  logic [REC_W-1:0]     ram_q [NCELL];
`ifdef MAZE_LINK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0]    idle_q, idle_d;
`endif

  // Strobe stage 2 high with stage 3 still low marks one transfer.
  assign evt = strb_q[1] & ~strb_q[2];

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    lat_d     = lat_q;
    done_d    = done_q;
    we_d      = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_q;
    mem_wdata = '0;
    ins       = part_q;
    for (int i = 0; i < NCHUNKS; i++)
      if (cnt_q == CNT_W'(i)) ins[i*CHUNK_W +: CHUNK_W] = data_s2_q;
`ifdef MAZE_LINK_TIMEOUT_EN
    idle_d = '0;
`endif
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      if (clr_q == LAST_CELL) state_d = ST_RUN;
      else clr_d = clr_q + 1'b1;
    end else if (evt) begin
      if (addr_s2_q == SYNC_ADDR) begin
        cnt_d  = '0;
        part_d = '0;
        done_d = 1'b0;
      end else if (addr_s2_q == DONE_ADDR) begin
        done_d = 1'b1;
        cnt_d  = '0;
      end else if (addr_s2_q >= NCELL_A) begin
        err_d = 1'b1;
      end else if (cnt_q != '0 && addr_s2_q != lat_q) begin
        // Address changed mid-record: restart with this chunk as chunk 0.
        err_d  = 1'b1;
        lat_d  = addr_s2_q;
        part_d = '0;
        part_d[CHUNK_W-1:0] = data_s2_q;
        cnt_d  = CNT_W'(1);
      end else begin
        part_d = ins;
        if (cnt_q == '0) lat_d = addr_s2_q;
        if (cnt_q == LAST_K) begin
          mem_we    = 1'b1;
          mem_waddr = (cnt_q == '0) ? addr_s2_q : lat_q;
          mem_wdata = ins;
          we_d      = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
`ifdef MAZE_LINK_TIMEOUT_EN
    else if (cnt_q != '0) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
        cnt_d  = '0;
        part_d = '0;
        err_d  = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      clr_q     <= '0;
      cnt_q     <= '0;
      part_q    <= '0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      strb_q    <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
`ifdef MAZE_LINK_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      done_q    <= done_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rd_q      <= (RD_ADDR < NCELL_A) ? ram_q[RD_ADDR] : '0;
      strb_q    <= {strb_q[1:0], LINK_STROBE};
      data_s1_q <= LINK_DATA;
      data_s2_q <= data_s1_q;
      addr_s1_q <= LINK_ADDR;
      addr_s2_q <= addr_s1_q;
`ifdef MAZE_LINK_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  // RAM contents are not reset; the CLEAR sweep zeroes them. A reset edge suppresses writes.
  always_ff @(posedge CLOCK) begin
    lat_q <= lat_d;
    if (mem_we && !RESET) ram_q[mem_waddr] <= mem_wdata;
  end

  assign RD_DATA  = rd_q;
  assign DONE     = done_q;
  assign BUSY     = (state_q == ST_CLEAR);
  assign REC_WE   = we_q;
  assign LINK_ERR = err_q;
endmodule

// File: tb/tb_maze_link_rx.sv
// Bench for maze_link_rx: transfer-level reference model (event queue + cell array) compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_maze_link_rx;
  localparam int ROWS = 4, COLS = 5, CW = 3, NCH = 3, AW = 5, TO = 50;
  localparam int NCELL = ROWS * COLS;
  localparam int RW = CW * NCH;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic [CW-1:0] LINK_DATA = '0;
  logic          LINK_STROBE = 1'b0;
  logic [AW-1:0] LINK_ADDR = '0;
  logic [AW-1:0] RD_ADDR = '0;
  logic [RW-1:0] RD_DATA;
  logic          DONE, BUSY, REC_WE, LINK_ERR;

  maze_link_rx #(.ROWS(ROWS), .COLS(COLS), .CHUNK_W(CW), .NCHUNKS(NCH), .ADDR_W(AW),
                 .TIMEOUT_CYC(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .LINK_DATA(LINK_DATA), .LINK_STROBE(LINK_STROBE),
    .LINK_ADDR(LINK_ADDR), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .DONE(DONE),
    .BUSY(BUSY), .REC_WE(REC_WE), .LINK_ERR(LINK_ERR));

  always #20 CLOCK = ~CLOCK;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic [AW-1:0] a; logic [CW-1:0] d; } ev_t;
  ev_t           evq[$];
  int            cyc = 0;
  bit            m_valid = 0, m_busy = 0, m_done = 0;
  int            clr_idx = 0, m_k = 0, m_lat = 0, m_idle = 0;
  logic [CW-1:0] m_chunk [NCH];
  logic [RW-1:0] m_mem [NCELL];
  bit            m_known [NCELL];
  logic [RW-1:0] exp_rd = '0;
  bit            exp_rd_known = 0, exp_we = 0, exp_err = 0;
  int            we_seen = 0, err_seen = 0;
  bit            rd_override = 0;
  int            rd_fixed = 0;

  task automatic apply(input logic [AW-1:0] a, input logic [CW-1:0] d);
    logic [RW-1:0] rec;
    m_idle = 0;
    if (int'(a) == 2**AW - 1) begin
      m_k = 0; m_done = 0;
    end else if (int'(a) == 2**AW - 2) begin
      m_done = 1; m_k = 0;
    end else if (int'(a) >= NCELL) begin
      exp_err = 1;
    end else begin
      if (m_k > 0 && int'(a) != m_lat) begin exp_err = 1; m_k = 0; end
      if (m_k == 0) m_lat = int'(a);
      m_chunk[m_k] = d;
      if (m_k == NCH - 1) begin
        rec = '0;
        for (int i = 0; i < NCH; i++) rec |= RW'(m_chunk[i]) << (i * CW);
        m_mem[m_lat] = rec; m_known[m_lat] = 1; exp_we = 1; m_k = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  always @(posedge CLOCK) begin
    ev_t ev;
    bit  have;
    cyc++;
    exp_we = 0; exp_err = 0; have = 0;
    while (evq.size() > 0 && evq[0].due < cyc) void'(evq.pop_front());
    if (evq.size() > 0 && evq[0].due == cyc) begin ev = evq.pop_front(); have = 1; end
    if (RESET) begin
      m_valid = 1; m_busy = 1; clr_idx = 0; m_k = 0; m_done = 0; m_idle = 0;
      exp_rd = '0; exp_rd_known = 1;
    end else begin
      if (int'(RD_ADDR) < NCELL) begin
        exp_rd = m_mem[RD_ADDR]; exp_rd_known = m_known[RD_ADDR];
      end else begin
        exp_rd = '0; exp_rd_known = 1;
      end
      if (m_busy) begin
        m_mem[clr_idx] = '0; m_known[clr_idx] = 1; clr_idx++;
        if (clr_idx == NCELL) m_busy = 0;
      end else if (have) begin
        apply(ev.a, ev.d);
      end
`ifdef MAZE_LINK_TIMEOUT_EN
      else if (m_k != 0) begin
        m_idle++;
        if (m_idle == TO) begin m_k = 0; m_idle = 0; exp_err = 1; end
      end else begin
        m_idle = 0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK) begin
    if (m_valid) begin
      check("busy", BUSY, m_busy);
      check("done", DONE, m_done);
      check("rec_we", REC_WE, exp_we);
      check("link_err", LINK_ERR, exp_err);
      if (exp_rd_known) check("rd_data", RD_DATA, exp_rd);
      we_seen  += int'(REC_WE);
      err_seen += int'(LINK_ERR);
    end
  end

  always @(posedge CLOCK) begin
    #2;
    RD_ADDR = rd_override ? AW'(rd_fixed) : AW'($urandom_range(2**AW - 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int a, input int d, input int hi = 2, input int lo = 2);
    @(negedge CLOCK);
    LINK_ADDR = AW'(a); LINK_DATA = CW'(d); LINK_STROBE = 1'b1;
    evq.push_back('{due: cyc + 3, a: AW'(a), d: CW'(d)});
    repeat (hi) @(negedge CLOCK);
    LINK_STROBE = 1'b0;
    repeat (lo) @(negedge CLOCK);
  endtask

  task automatic do_reset();
    @(negedge CLOCK); RESET = 1'b1;
    @(negedge CLOCK); RESET = 1'b0;
  endtask

  task automatic busy_len(output int c);
    c = 0;
    while (BUSY === 1'b1 && c < 100) begin @(negedge CLOCK); c++; end
  endtask

  task automatic read_cell(input int a, output logic [RW-1:0] v);
    rd_override = 1; rd_fixed = a;
    repeat (2) @(negedge CLOCK);
    v = RD_DATA;
    rd_override = 0;
  endtask

  initial begin
    int c, w0, e0, cur, a, r;
    logic [RW-1:0] v;

    do_reset();
    check("rst_rd_data", RD_DATA, 0);
    check("rst_done", DONE, 0);
    check("rst_rec_we", REC_WE, 0);
    check("rst_link_err", LINK_ERR, 0);
    check("rst_busy", BUSY, 1);
    busy_len(c);
    check("busy_len_first", c, NCELL);

    // Garbage records, then a fresh reset must wipe them.
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(NCELL - 1);
      send(31, 0);
      for (int j = 0; j < NCH; j++) send(a, $urandom_range(7));
    end
    repeat (4) @(negedge CLOCK);
    do_reset();
    busy_len(c);
    check("busy_len", c, 20);
    for (int i = 0; i < NCELL; i++) begin
      read_cell(i, v);
      check($sformatf("clr_rd[%0d]", i), v, 0);
    end

    // Record assembly.
    w0 = we_seen;
    send(31, 0); send(7, 3'b101); send(7, 3'b010); send(7, 3'b111);
    repeat (4) @(negedge CLOCK);
    check("asm_we_pulses", we_seen - w0, 1);
    read_cell(7, v);
    check("asm_rec7", v, 9'b111_010_101);

    // Framing error.
    e0 = err_seen;
    send(31, 0); send(3, 1); send(4, 2);
    repeat (4) @(negedge CLOCK);
    check("frm_err_pulses", err_seen - e0, 1);
    send(4, 3); send(4, 4);
    repeat (4) @(negedge CLOCK);
    read_cell(4, v);
    check("frm_rec4", v, 9'h11A);
    read_cell(3, v);
    check("frm_rec3", v, 0);

    // Markers.
    send(30, 0);
    repeat (4) @(negedge CLOCK);
    check("done_set", DONE, 1);
    repeat (100) @(negedge CLOCK);
    check("done_held", DONE, 1);
    send(31, 0);
    repeat (4) @(negedge CLOCK);
    check("done_clr", DONE, 0);
    read_cell(7, v);
    check("sync_keeps_ram", v, 9'h1D5);
    e0 = err_seen; w0 = we_seen;
    send(25, 5);
    repeat (4) @(negedge CLOCK);
    check("bad_addr_err", err_seen - e0, 1);
    check("bad_addr_nowe", we_seen - w0, 0);

    // Reset after a partial record, then again mid-sweep.
    send(9, 6);
    repeat (4) @(negedge CLOCK);
    do_reset();
    repeat (10) @(negedge CLOCK);
    do_reset();
    busy_len(c);
    check("busy_len_restart", c, 20);
    send(9, 1); send(9, 2);
    repeat (4) @(negedge CLOCK);
    read_cell(9, v);
    check("partial_gone", v, 0);

`ifdef MAZE_LINK_TIMEOUT_EN
    e0 = err_seen;
    send(31, 0); send(11, 5);
    repeat (55) @(negedge CLOCK);
    check("timeout_err", err_seen - e0, 1);
    send(11, 1); send(11, 2); send(11, 3);
    repeat (4) @(negedge CLOCK);
    read_cell(11, v);
    check("timeout_rec11", v, 9'h0D1);
`endif

    // Randomized traffic against the model.
    cur = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(99);
      if (r < 5) a = 31;
      else if (r < 8) a = 30;
      else if (r < 14) a = $urandom_range(29, NCELL);
      else if (r < 75) a = cur;
      else begin cur = $urandom_range(NCELL - 1); a = cur; end
      send(a, $urandom_range(7), $urandom_range(3, 1), $urandom_range(3, 1));
      if ($urandom_range(199) == 0) do_reset();
    end
    repeat (10) @(negedge CLOCK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
